i2c_slave_target: RTL and testbench

I2C target (slave) endpoint: the responder for the team's `sda_generate` I2C master FSM. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, and ACKs. Written bytes go out through a strobe interface. Read bytes come in through a request interface. The block sits at the pad boundary of a peripheral and drives SDA open-drain only.

---
 rtl/i2c_slave_target.sv | 174 +++++++++++++++++
 tb/tb_i2c_slave_target.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_target.sv
// rtl/i2c_slave_target.sv - I2C target endpoint: oversampled SCL/SDA, address match, byte strobes, open-drain SDA
module i2c_slave_target #(
  parameter logic [6:0] OWN_ADDR = 7'h50,
  parameter int         DATA_LEN = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scl_i,
  input  logic                sda_i,
  output logic                sda_oe,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                rx_valid,
  input  logic [DATA_LEN-1:0] tx_data,
  output logic                tx_req,
  output logic                rw,
  output logic                busy,
  output logic                stop_det
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] WR_BYTE   = 3'd3;
  localparam logic [2:0] WR_ACK    = 3'd4;
  localparam logic [2:0] RD_BYTE   = 3'd5;
  localparam logic [2:0] RD_ACK    = 3'd6;
  localparam logic [2:0] WAIT_STOP = 3'd7;

  // Shift register holds only the bits not yet consumed: the MSB of a read byte
  // is driven straight from tx_data, the last bit of a write comes from the bus.
  localparam int SHW = (DATA_LEN - 1 > 7) ? DATA_LEN - 1 : 7;

  // [0] first sync stage, [1] synced value, [2] previous synced value
  logic [2:0]     scl_sync;
  logic [2:0]     sda_sync;
  logic [2:0]     state;
  logic [3:0]     cnt;
  logic [SHW-1:0] shreg;

  logic scl_rise, scl_fall, scl_high, sda_bit, start_c, stop_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], scl_i};
      sda_sync <= {sda_sync[1:0], sda_i};
    end
  end

  // SCL must be stable high across the SDA edge, so a simultaneous change is a bit edge
  assign scl_high = scl_sync[1] & scl_sync[2];
  assign scl_rise = scl_sync[1] & ~scl_sync[2];
  assign scl_fall = ~scl_sync[1] & scl_sync[2];
  assign sda_bit  = sda_sync[1];
  assign start_c  = ~sda_sync[1] & sda_sync[2] & scl_high;
  assign stop_c   = sda_sync[1] & ~sda_sync[2] & scl_high;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      shreg    <= '0;
      sda_oe   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      rw       <= 1'b0;
      busy     <= 1'b0;
      stop_det <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      stop_det <= 1'b0;
      if (stop_c) begin
        state    <= IDLE;
        cnt      <= 4'd0;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        stop_det <= 1'b1;
      end else if (start_c) begin
        state  <= ADDR;
        cnt    <= 4'd0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg <= {shreg[SHW-2:0], sda_bit};
            if (cnt == 4'd7) begin
              cnt <= 4'd0;
              if (shreg[6:0] == OWN_ADDR) begin
                rw    <= sda_bit;
                state <= ADDR_ACK;
              end else begin
                state <= WAIT_STOP;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (cnt == 4'd0) begin
              sda_oe <= 1'b1;
              busy   <= 1'b1;
              tx_req <= rw;
              cnt    <= 4'd1;
            end else if (rw) begin
              shreg  <= SHW'(tx_data[DATA_LEN-2:0]);
              sda_oe <= ~tx_data[DATA_LEN-1];
              cnt    <= 4'd1;
              state  <= RD_BYTE;
            end else begin
              sda_oe <= 1'b0;
              cnt    <= 4'd0;
              state  <= WR_BYTE;
            end
          end
          WR_BYTE: if (scl_rise) begin
            shreg <= {shreg[SHW-2:0], sda_bit};
            if (cnt == 4'(DATA_LEN - 1)) begin
              rx_data  <= {shreg[DATA_LEN-2:0], sda_bit};
              rx_valid <= 1'b1;
              cnt      <= 4'd0;
              state    <= WR_ACK;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          WR_ACK: if (scl_fall) begin
            if (cnt == 4'd0) begin
              sda_oe <= 1'b1;
              cnt    <= 4'd1;
            end else begin
              sda_oe <= 1'b0;
              cnt    <= 4'd0;
              state  <= WR_BYTE;
            end
          end
          RD_BYTE: if (scl_fall) begin
            if (cnt == 4'(DATA_LEN)) begin
              sda_oe <= 1'b0;
              cnt    <= 4'd0;
              state  <= RD_ACK;
            end else begin
              sda_oe <= ~shreg[DATA_LEN-2];
              shreg  <= shreg << 1;
              cnt    <= cnt + 4'd1;
            end
          end
          RD_ACK: begin
            // cnt marks that the master ACKed and the next byte is being fetched
            if (scl_rise && cnt == 4'd0) begin
              if (!sda_bit) begin
                tx_req <= 1'b1;
                cnt    <= 4'd1;
              end else begin
                state <= WAIT_STOP;
              end
            end else if (scl_fall && cnt == 4'd1) begin
              shreg  <= SHW'(tx_data[DATA_LEN-2:0]);
              sda_oe <= ~tx_data[DATA_LEN-1];
              cnt    <= 4'd1;
              state  <= RD_BYTE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_target.sv
// tb/tb_i2c_slave_target.sv - directed and randomized I2C master transactions against a transaction-level model
module tb_i2c_slave_target;
  localparam int Q = 100;
  localparam logic [6:0] OWN = 7'h50;

  logic       clk;
  logic       rst_n;
  logic       scl;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       rw;
  logic       busy;
  logic       stop_det;

  i2c_slave_target #(.OWN_ADDR(OWN), .DATA_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sda_bus), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req),
    .rw(rw), .busy(busy), .stop_det(stop_det)
  );

  assign sda_bus = sda_m & ~sda_oe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_txreq;
  int n_stop;
  bit oe_seen;
  bit busy_seen;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] pay[4];

  // Bus-side monitor and tx byte supplier
  always @(negedge clk) begin
    if (rx_valid) rxq.push_back(rx_data);
    if (tx_req) begin
      n_txreq++;
      if (txq.size() > 0) tx_data = txq.pop_front();
      else tx_data = 8'hEE;
    end
    if (stop_det) n_stop++;
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rxq.delete();
    n_txreq   = 0;
    n_stop    = 0;
    oe_seen   = 1'b0;
    busy_seen = 1'b0;
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    sda_m = b; #Q;
    scl = 1'b1; #Q;
    s = sda_bus; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic start_cond();
    sda_m = 1'b1; scl = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic rstart_cond();
    sda_m = 1'b1; #Q;
    scl = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; #Q;
    scl = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input bit mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(mack ? 1'b0 : 1'b1, s);
  endtask

  // Whole transaction; model: target answers only its own address, ACKs every written byte,
  // and returns requested bytes in order, one tx_req per byte read.
  task automatic do_xfer(input logic [6:0] a, input logic r, input int n, input string tag);
    logic       ack;
    logic [7:0] got;
    bit         match;
    int         exp_rx;
    match = (a == OWN);
    clear_mon();
    txq.delete();
    if (r && match) for (int i = 0; i < n; i++) txq.push_back(pay[i]);
    start_cond();
    write_byte({a, r}, ack);
    check({tag, "_addr_ack"}, ack, !match);
    if (!r) begin
      for (int i = 0; i < n; i++) begin
        write_byte(pay[i], ack);
        check({tag, "_data_ack"}, ack, !match);
      end
    end else if (match) begin
      check({tag, "_rw"}, rw, 1);
      for (int i = 0; i < n; i++) begin
        read_byte(i < n - 1, got);
        check({tag, "_rd_data"}, got, pay[i]);
      end
    end
    if (match) check({tag, "_busy_mid"}, busy, 1);
    stop_cond();
    #(4*Q);
    exp_rx = (match && !r) ? n : 0;
    check({tag, "_rx_count"}, rxq.size(), exp_rx);
    if (rxq.size() == exp_rx)
      for (int i = 0; i < exp_rx; i++) check({tag, "_rx_data"}, rxq[i], pay[i]);
    check({tag, "_tx_req_count"}, n_txreq, (match && r) ? n : 0);
    check({tag, "_stop_det"}, n_stop, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_oe_end"}, sda_oe, 0);
    if (!match) begin
      check({tag, "_oe_never"}, oe_seen, 0);
      check({tag, "_busy_never"}, busy_seen, 0);
    end
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] got;
    logic [6:0] ra;
    logic       rr;
    int         rn;

    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
    clear_mon();
    #40;
    check("rst_sda_oe", sda_oe, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_req", tx_req, 0);
    check("rst_rw", rw, 0);
    check("rst_busy", busy, 0);
    check("rst_stop_det", stop_det, 0);
    #10 rst_n = 1'b1;
    #(2*Q);

    pay[0] = 8'hA5;
    do_xfer(7'h50, 1'b0, 1, "write");

    pay[0] = 8'h11;
    do_xfer(7'h51, 1'b0, 1, "mismatch");

    pay[0] = 8'h3C; pay[1] = 8'hC3;
    do_xfer(7'h50, 1'b1, 2, "read");

    // Repeated START: write then read without STOP
    clear_mon();
    txq.delete();
    start_cond();
    write_byte(8'hA0, ack);
    check("sr_addr_w_ack", ack, 0);
    check("sr_rw_w", rw, 0);
    write_byte(8'h12, ack);
    check("sr_data_ack", ack, 0);
    pay[0] = 8'($urandom);
    txq.push_back(pay[0]);
    rstart_cond();
    write_byte(8'hA1, ack);
    check("sr_addr_r_ack", ack, 0);
    check("sr_rw_r", rw, 1);
    check("sr_txreq_at_addr_ack", n_txreq, 1);
    read_byte(1'b0, got);
    check("sr_rd_data", got, pay[0]);
    stop_cond();
    #(4*Q);
    check("sr_rx_count", rxq.size(), 1);
    if (rxq.size() == 1) check("sr_rx_data", rxq[0], 8'h12);
    check("sr_txreq_total", n_txreq, 1);

    // Abort: STOP after four data bits
    clear_mon();
    start_cond();
    write_byte(8'hA0, ack);
    check("abort_addr_ack", ack, 0);
    for (int i = 0; i < 4; i++) bit_xfer(1'($urandom), s);
    stop_cond();
    #(4*Q);
    check("abort_rx_count", rxq.size(), 0);
    check("abort_oe", sda_oe, 0);
    check("abort_busy", busy, 0);
    check("abort_stop_det", n_stop, 1);

    // Reset while the target pulls SDA during a read
    clear_mon();
    txq.delete();
    txq.push_back(8'h00);
    start_cond();
    write_byte(8'hA1, ack);
    check("rstm_addr_ack", ack, 0);
    for (int k = 0; k < 200 && !sda_oe; k++) @(negedge clk);
    check("rstm_oe_before", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check("rstm_oe_released", sda_oe, 0);
    #19 rst_n = 1'b1;
    #(Q);
    oe_seen = 1'b0;
    for (int i = 0; i < 9; i++) bit_xfer(1'b1, s);
    check("rstm_no_response", oe_seen, 0);
    check("rstm_busy", busy, 0);
    stop_cond();
    #(2*Q);
    pay[0] = 8'($urandom);
    do_xfer(OWN, 1'b0, 1, "post_reset");

    // Randomized transactions
    for (int t = 0; t < 6; t++) begin
      if ($urandom_range(1, 0) == 1) ra = OWN;
      else begin
        ra = 7'($urandom);
        if (ra == OWN) ra = ra ^ 7'h01;
      end
      rr = 1'($urandom);
      rn = $urandom_range(3, 1);
      for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
      do_xfer(ra, rr, rn, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
